qdr_multiport_arbiter: RTL and testbench
========================================

// Module: qdr_multiport_arbiter
// PURPOSE
//  Parametrised QDR command arbiter; successor to the two-way fabric/backdoor sniffer arbitration.
//  Port 0 is the fabric slave and the default owner. Ports 1..NUM_PORTS-1 are backdoor requesters
//  using a req/ack handshake. Each read return is tagged and routed to the port that issued it.
//  Sits between the user-facing interfaces and a single QDR controller master port.
// PARAMETERS
//  NUM_PORTS       3   total ports incl. fabric port 0; range 2..8
//  QDR_ADDR_WIDTH  21  QDR word address width
//  QDR_DATA_WIDTH  36  per-edge data width; bus is 2*QDR_DATA_WIDTH
//  QDR_BW_WIDTH    2   per-edge byte-enable width; bus is 2*QDR_BW_WIDTH
//  QDR_LATENCY     10  cycles from master_rd_strb to master_rd_dvld; range 1..31
//  MAX_BURST       1   commands a backdoor port may issue per grant; range 1..16
//  PRIO_MODE       0   0 = round-robin among backdoor ports; 1 = fixed, lowest index wins
// PORTS
//  qdr_clk        in   1            sole clock
//  qdr_rst        in   1            asynchronous, active-high reset
//  slave_addr     in   32           fabric address; bits [QDR_ADDR_WIDTH-1:0] used
//  slave_wr_strb  in   1            fabric write command
//  slave_rd_strb  in   1            fabric read command
//  slave_wr_data  in   2*DW         fabric write data
//  slave_wr_be    in   2*BW         fabric byte enables
//  slave_ack      out  1            fabric command accepted this cycle
//  slave_rd_data  out  2*DW         read data, broadcast to all ports
//  slave_rd_dvld  out  1            read data valid, tagged for port 0
//  bp_req         in   NP-1         per backdoor port: request pending
//  bp_r / bp_w    in   NP-1 each    per backdoor port: read / write command
//  bp_addr        in   (NP-1)*32    flattened addresses; port i is slice i-1
//  bp_d           in   (NP-1)*2*DW  flattened write data
//  bp_be          in   (NP-1)*2*BW  flattened byte enables
//  bp_ack         out  NP-1         one-hot; command of port i is taken this cycle
//  bp_rd_dvld     out  NP-1         read data valid, tagged for backdoor port i
//  master_addr, master_wr_strb, master_rd_strb, master_wr_data, master_wr_be  out  to QDR controller
//  master_rd_data in   2*DW         data from QDR controller
//  master_rd_dvld in   1            valid from QDR controller
//  rd_orphan      out  1            sticky: master_rd_dvld seen with no tag; cleared only by reset
// BEHAVIOUR
//  FSM states, all registered:
//   SLAVE: slave_ack = 1.
//    - Any bp_req with no slave strobe -> GRANT.
//    - Any bp_req with a slave strobe -> SLAVE_WAIT.
//   SLAVE_WAIT: one cycle; slave_ack = 0 -> GRANT.
//   GRANT: bp_ack[sel] = 1 while cnt < MAX_BURST and bp_req[sel] = 1; cnt increments on each ack.
//    - Exit to TURN when cnt reaches MAX_BURST or bp_req[sel] drops.
//   TURN: one idle bubble -> SLAVE.
//  sel is latched on leaving SLAVE.
//   - PRIO_MODE 0: first requester at or after rr_ptr, wrapping.
//   - PRIO_MODE 1: lowest requesting index.
//   - rr_ptr <= sel+1 (mod NP-1) on TURN.
//  Command outputs are combinational from state plus inputs:
//   - master_*_strb = slave strobe & slave_ack | bp_r/bp_w[sel] & bp_ack[sel].
//   - master_addr: slave slice in SLAVE, otherwise bp_addr[sel].
//   - master_wr_data / master_wr_be: slave in SLAVE and SLAVE_WAIT, otherwise bp[sel].
//  A simultaneous bp_r and bp_w from one port issues both strobes in the same cycle (QDR separate ports).
//  Tag pipe: QDR_LATENCY-deep shift register of {valid, port id}; pushed every cycle with valid = master_rd_strb.
//   - slave_rd_dvld = master_rd_dvld & tag valid & id == 0.
//   - bp_rd_dvld[i-1] = master_rd_dvld & tag valid & id == i.
//   - master_rd_dvld with tag invalid sets rd_orphan; the beat is not forwarded.
//  Reset (any time, async):
//   - State = SLAVE, so slave_ack = 1 immediately. bp_ack = 0, rr_ptr = 0, cnt = 0, rd_orphan = 0.
//   - Tag pipe cleared; in-flight reads are dropped, and their late returns flag rd_orphan.
//  Worst-case wait for a backdoor port: (NP-1)*(MAX_BURST+3) cycles, PRIO_MODE 0 only.
//  The fabric slave is stalled at most MAX_BURST+2 cycles per backdoor grant.
// STRUCTURE
//  Shared package qdr_arb_pkg:
//   - state localparams SLAVE / SLAVE_WAIT / GRANT / TURN.
//   - function clog2.
//   - PRIO_RR / PRIO_FIXED constants.
//  Sub-module qdr_rd_tag_pipe: parametrised shift register for {valid, id}, width clog2(NP)+1, depth QDR_LATENCY.
// TESTING
//  1. Fabric-only reads at addr 0x10, 0x11, no bp_req
//     -> slave_ack held at 1; slave_rd_dvld exactly 10 cycles after each strobe; bp_rd_dvld = 0.
//  2. bp_req[0] with bp_r, addr 0x55, while slave_wr_strb is active
//     -> SLAVE_WAIT for 1 cycle, then bp_ack[0] for 1 cycle with master_addr = 0x55.
//     -> bp_rd_dvld[0] 10 cycles later; slave sees no dvld for that beat.
//  3. NP = 4, bp_req = 3'b111 held, PRIO_MODE 0
//     -> grants in order port1, port2, port3, port1; PRIO_MODE 1 gives port1 every time.
//  4. MAX_BURST = 4, bp_req[1] held for 6 commands
//     -> 4 bp_ack, then TURN, then SLAVE for at least 1 cycle, then 2 more acks.
//     -> bp_req dropped after 2 commands gives exactly 2 acks.
//  5. Reset asserted 3 cycles after a backdoor read
//     -> outputs at reset values; the late master_rd_dvld sets rd_orphan = 1 and produces no dvld output.
//  6. Same-cycle bp_r and bp_w on port 2 at 0x7
//     -> both master strobes high together with master_addr = 0x7; only the read is tagged.

Source files
------------

// File: rtl/qdr_arb_pkg.sv
// qdr_arb_pkg: shared states, priority modes and width helper for the QDR multiport arbiter.
package qdr_arb_pkg;

    typedef enum logic [1:0] {
        SLAVE      = 2'd0,
        SLAVE_WAIT = 2'd1,
        GRANT      = 2'd2,
        TURN       = 2'd3
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/qdr_rd_tag_pipe.sv
// qdr_rd_tag_pipe: fixed-latency shift register carrying {valid, port id} alongside each QDR read.
module qdr_rd_tag_pipe #(
    parameter int W     = 3,
    parameter int DEPTH = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_tag,
    output logic [W-1:0] o_tag
);

    logic [DEPTH-1:0][W-1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_tag;
            for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
    end

    assign o_tag = r_sr[DEPTH-1];

endmodule

// File: rtl/qdr_multiport_arbiter.sv
// qdr_multiport_arbiter: shares one QDR controller between the fabric slave (port 0, default owner)
// and req/ack backdoor ports, routing each read return to the port that issued it.
module qdr_multiport_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 3,
    parameter int QDR_ADDR_WIDTH = 21,
    parameter int QDR_DATA_WIDTH = 36,
    parameter int QDR_BW_WIDTH   = 2,
    parameter int QDR_LATENCY    = 10,
    parameter int MAX_BURST      = 1,
    parameter int PRIO_MODE      = 0
) (
    input  logic                                      qdr_clk,
    input  logic                                      qdr_rst,
    input  logic [31:0]                               slave_addr,
    input  logic                                      slave_wr_strb,
    input  logic                                      slave_rd_strb,
    input  logic [2*QDR_DATA_WIDTH-1:0]               slave_wr_data,
    input  logic [2*QDR_BW_WIDTH-1:0]                 slave_wr_be,
    output logic                                      slave_ack,
    output logic [2*QDR_DATA_WIDTH-1:0]               slave_rd_data,
    output logic                                      slave_rd_dvld,
    input  logic [NUM_PORTS-2:0]                      bp_req,
    input  logic [NUM_PORTS-2:0]                      bp_r,
    input  logic [NUM_PORTS-2:0]                      bp_w,
    input  logic [(NUM_PORTS-1)*32-1:0]               bp_addr,
    input  logic [(NUM_PORTS-1)*2*QDR_DATA_WIDTH-1:0] bp_d,
    input  logic [(NUM_PORTS-1)*2*QDR_BW_WIDTH-1:0]   bp_be,
    output logic [NUM_PORTS-2:0]                      bp_ack,
    output logic [NUM_PORTS-2:0]                      bp_rd_dvld,
    output logic [QDR_ADDR_WIDTH-1:0]                 master_addr,
    output logic                                      master_wr_strb,
    output logic                                      master_rd_strb,
    output logic [2*QDR_DATA_WIDTH-1:0]               master_wr_data,
    output logic [2*QDR_BW_WIDTH-1:0]                 master_wr_be,
    input  logic [2*QDR_DATA_WIDTH-1:0]               master_rd_data,
    input  logic                                      master_rd_dvld,
    output logic                                      rd_orphan
);

    localparam int NB  = NUM_PORTS - 1;
    localparam int IW  = clog2(NUM_PORTS);
    localparam int CW  = clog2(MAX_BURST + 1);
    localparam int DW2 = 2 * QDR_DATA_WIDTH;
    localparam int BW2 = 2 * QDR_BW_WIDTH;

    arb_state_t          r_state, w_next;
    logic [IW-1:0]       r_sel, r_rr_ptr, w_pick;
    logic [CW-1:0]       r_cnt;
    logic                r_orphan;
    logic                w_slave_strb, w_any_req, w_sel_req, w_ack, w_slave_ack, w_hit;
    logic [NB-1:0]       w_sel_oh;
    logic                w_bp_r, w_bp_w;
    logic [QDR_ADDR_WIDTH-1:0] w_bp_addr;
    logic [DW2-1:0]      w_bp_d;
    logic [BW2-1:0]      w_bp_be;
    logic [IW:0]         w_tag_in, w_tag_out;
    logic                w_unused;

    assign w_slave_strb = slave_rd_strb | slave_wr_strb;
    assign w_any_req    = |bp_req;
    assign w_unused     = ^{slave_addr, bp_addr};

    // Candidate for the next grant: scan from rr_ptr (wrapping) or from index 0 in fixed mode.
    always_comb begin
        w_pick = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            for (int j = 0; j < NB; j++) begin
                if (bp_req[j] && j == ((PRIO_MODE == PRIO_FIXED) ? k : (int'(r_rr_ptr) + k) % NB))
                    w_pick = IW'(j);
            end
        end
    end

    always_comb begin
        w_sel_oh  = '0;
        w_sel_req = 1'b0;
        w_bp_r    = 1'b0;
        w_bp_w    = 1'b0;
        w_bp_addr = '0;
        w_bp_d    = '0;
        w_bp_be   = '0;
        for (int i = 0; i < NB; i++) begin
            if (r_sel == IW'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_req   = bp_req[i];
                w_bp_r      = bp_r[i];
                w_bp_w      = bp_w[i];
                w_bp_addr   = bp_addr[i*32 +: QDR_ADDR_WIDTH];
                w_bp_d      = bp_d[i*DW2 +: DW2];
                w_bp_be     = bp_be[i*BW2 +: BW2];
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ack       = 1'b0;
        w_slave_ack = 1'b0;
        case (r_state)
            SLAVE: begin
                w_slave_ack = 1'b1;
                if (w_any_req) w_next = w_slave_strb ? SLAVE_WAIT : GRANT;
            end
            SLAVE_WAIT: w_next = GRANT;
            GRANT: begin
                w_ack = w_sel_req && (r_cnt < CW'(MAX_BURST));
                if (!w_sel_req || (w_ack && r_cnt == CW'(MAX_BURST - 1))) w_next = TURN;
            end
            default: w_next = SLAVE;
        endcase
    end

    always_ff @(posedge qdr_clk or posedge qdr_rst) begin
        if (qdr_rst) begin
            r_state  <= SLAVE;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_orphan <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == SLAVE && w_any_req) begin
                r_sel <= w_pick;
                r_cnt <= '0;
            end
            if (w_ack) r_cnt <= r_cnt + 1'b1;
            if (r_state == TURN) r_rr_ptr <= (r_sel == IW'(NB - 1)) ? '0 : r_sel + 1'b1;
            if (master_rd_dvld && !w_tag_out[IW]) r_orphan <= 1'b1;
        end
    end

    assign slave_ack      = w_slave_ack;
    assign bp_ack         = w_ack ? w_sel_oh : '0;
    assign master_rd_strb = (slave_rd_strb & w_slave_ack) | (w_bp_r & w_ack);
    assign master_wr_strb = (slave_wr_strb & w_slave_ack) | (w_bp_w & w_ack);
    assign master_addr    = (r_state == SLAVE) ? slave_addr[QDR_ADDR_WIDTH-1:0] : w_bp_addr;
    // Write data follows the fabric through the wait cycle so its last beat is not disturbed.
    assign master_wr_data = (r_state == SLAVE || r_state == SLAVE_WAIT) ? slave_wr_data : w_bp_d;
    assign master_wr_be   = (r_state == SLAVE || r_state == SLAVE_WAIT) ? slave_wr_be : w_bp_be;

    assign w_tag_in = {master_rd_strb, w_slave_ack ? IW'(0) : IW'(r_sel + 1'b1)};

    qdr_rd_tag_pipe #(
        .W     (IW + 1),
        .DEPTH (QDR_LATENCY)
    ) u_tag_pipe (
        .clk   (qdr_clk),
        .rst   (qdr_rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_hit         = master_rd_dvld & w_tag_out[IW];
    assign slave_rd_data = master_rd_data;
    assign slave_rd_dvld = w_hit && (w_tag_out[IW-1:0] == '0);
    assign rd_orphan     = r_orphan;

    always_comb begin
        bp_rd_dvld = '0;
        for (int i = 0; i < NB; i++) bp_rd_dvld[i] = w_hit && (w_tag_out[IW-1:0] == IW'(i + 1));
    end

endmodule

// File: tb/tb_qdr_multiport_arbiter.sv
// tb_qdr_multiport_arbiter: directed and random traffic against a transaction-level arbitration
// and read-routing reference model.
module tb_qdr_multiport_arbiter;

    localparam int NP   = 4;
    localparam int NB   = NP - 1;
    localparam int LAT  = 10;
    localparam int MB   = 4;
    localparam int PRIO = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       slave_addr;
    logic              slave_wr_strb, slave_rd_strb;
    logic [71:0]       slave_wr_data;
    logic [3:0]        slave_wr_be;
    logic              slave_ack;
    logic [71:0]       slave_rd_data;
    logic              slave_rd_dvld;
    logic [NB-1:0]     bp_req, bp_r, bp_w, bp_ack, bp_rd_dvld;
    logic [NB*32-1:0]  bp_addr;
    logic [NB*72-1:0]  bp_d;
    logic [NB*4-1:0]   bp_be;
    logic [20:0]       master_addr;
    logic              master_wr_strb, master_rd_strb;
    logic [71:0]       master_wr_data;
    logic [3:0]        master_wr_be;
    logic [71:0]       master_rd_data;
    logic              master_rd_dvld;
    logic              rd_orphan;

    qdr_multiport_arbiter #(
        .NUM_PORTS(NP), .QDR_ADDR_WIDTH(21), .QDR_DATA_WIDTH(36), .QDR_BW_WIDTH(2),
        .QDR_LATENCY(LAT), .MAX_BURST(MB), .PRIO_MODE(PRIO)
    ) dut (
        .qdr_clk(clk), .qdr_rst(rst),
        .slave_addr(slave_addr), .slave_wr_strb(slave_wr_strb), .slave_rd_strb(slave_rd_strb),
        .slave_wr_data(slave_wr_data), .slave_wr_be(slave_wr_be), .slave_ack(slave_ack),
        .slave_rd_data(slave_rd_data), .slave_rd_dvld(slave_rd_dvld),
        .bp_req(bp_req), .bp_r(bp_r), .bp_w(bp_w), .bp_addr(bp_addr), .bp_d(bp_d), .bp_be(bp_be),
        .bp_ack(bp_ack), .bp_rd_dvld(bp_rd_dvld),
        .master_addr(master_addr), .master_wr_strb(master_wr_strb), .master_rd_strb(master_rd_strb),
        .master_wr_data(master_wr_data), .master_wr_be(master_wr_be),
        .master_rd_data(master_rd_data), .master_rd_dvld(master_rd_dvld), .rd_orphan(rd_orphan)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    // requester scripts: commands remaining and the command currently presented
    int rem[NB];
    logic c_r[NB], c_w[NB];
    logic [31:0] c_addr[NB];
    logic [71:0] c_d[NB];
    logic [3:0] c_be[NB];
    logic s_rst, s_sr, s_sw;
    logic [31:0] s_sa;
    logic [71:0] s_sd;
    logic [3:0] s_sbe;
    bit rnd;
    // reference model: current owner (-1 = fabric), fabric-drain wait, acks served, bubble pending
    int owner, hold, served, bubble, rr, stall;
    bit m_orph;
    int waited[NB];
    int exp_tag[8192];
    bit rd_hist[8192];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic [71:0] rnd72();
        logic [95:0] v;
        v = {$urandom, $urandom, $urandom};
        return v[71:0];
    endfunction

    task automatic new_cmd(input int i);
        c_r[i]    = 1'($urandom_range(0, 1));
        c_w[i]    = 1'($urandom_range(0, 1));
        c_addr[i] = $urandom;
        c_d[i]    = rnd72();
        c_be[i]   = 4'($urandom_range(0, 15));
    endtask

    function automatic int m_pick();
        for (int k = 0; k < NB; k++) begin
            int p;
            p = (PRIO == 1) ? k : (rr + k) % NB;
            if (rem[p] > 0) return p;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic [NB-1:0] e_ack, e_bd;
        bit e_sack, e_rd, e_wr;
        bit req[NB];
        logic [20:0] e_addr;
        logic [71:0] e_d;
        logic [3:0] e_be;
        int e_id, t;
        for (int i = 0; i < NB; i++) req[i] = rem[i] > 0;
        if (rst) begin
            owner = -1; hold = 0; served = 0; bubble = 0; rr = 0; m_orph = 0;
            for (int k = 0; k <= LAT; k++) exp_tag[cyc + k] = -1;
        end
        e_ack = '0; e_sack = 0; e_rd = 0; e_wr = 0; e_id = -1;
        e_addr = '0; e_d = '0; e_be = '0;
        if (owner < 0 && bubble == 0) begin
            e_sack = 1; e_rd = slave_rd_strb; e_wr = slave_wr_strb; e_id = 0;
            e_addr = slave_addr[20:0]; e_d = slave_wr_data; e_be = slave_wr_be;
        end else if (owner >= 0 && hold == 0 && req[owner]) begin
            e_ack = NB'(1) << owner; e_rd = c_r[owner]; e_wr = c_w[owner]; e_id = owner + 1;
            e_addr = c_addr[owner][20:0]; e_d = c_d[owner]; e_be = c_be[owner];
        end
        chk("slave_ack", slave_ack, e_sack);
        chk("bp_ack", bp_ack, e_ack);
        chk("rd_strb", master_rd_strb, e_rd);
        chk("wr_strb", master_wr_strb, e_wr);
        if (e_rd || e_wr) chk("addr", master_addr, e_addr);
        if (e_wr) begin
            chk("wr_data", master_wr_data, e_d);
            chk("wr_be", master_wr_be, e_be);
        end
        t = exp_tag[cyc];
        e_bd = (master_rd_dvld && t > 0) ? NB'(1) << (t - 1) : '0;
        chk("slave_dvld", slave_rd_dvld, master_rd_dvld && t == 0);
        chk("bp_dvld", bp_rd_dvld, e_bd);
        chk("rd_data", slave_rd_data, master_rd_data);
        chk("orphan", rd_orphan, m_orph);
        for (int i = 0; i < NB; i++) begin
            if (e_ack[i]) begin
                chk("wait_bound", waited[i] <= NB * (MB + 3), 1'b1);
                waited[i] = 0;
            end else waited[i] = req[i] ? waited[i] + 1 : 0;
        end
        if (!slave_ack) stall++;
        else begin
            if (stall > 0) chk("fabric_stall", stall <= MB + 2, 1'b1);
            stall = 0;
        end
        if (!rst) begin
            if (e_rd) exp_tag[cyc + LAT] = e_id;
            rd_hist[cyc] = e_rd;
            if (master_rd_dvld && t < 0) m_orph = 1;
            if (bubble != 0) bubble = 0;
            else if (owner < 0) begin
                owner = m_pick();
                hold = (slave_rd_strb || slave_wr_strb) ? 1 : 0;
                served = 0;
            end else if (hold > 0) hold--;
            else begin
                if (e_ack != 0) served++;
                if (!req[owner] || served == MB) begin
                    rr = (owner + 1) % NB; owner = -1; bubble = 1;
                end
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (e_ack[i]) begin
                rem[i]--;
                if (rnd) new_cmd(i);
            end
            if (rnd && rem[i] == 0 && $urandom_range(0, 7) == 0) begin
                rem[i] = $urandom_range(1, 6);
                new_cmd(i);
            end
        end
        if (rnd) begin
            s_sr = $urandom_range(0, 3) == 0; s_sw = $urandom_range(0, 3) == 0;
            s_sa = $urandom; s_sd = rnd72(); s_sbe = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic cycle1();
        @(posedge clk);
        #1;
        cyc++;
        rst = s_rst;
        master_rd_dvld = (cyc > LAT) ? rd_hist[cyc - LAT] : 1'b0;
        master_rd_data = rnd72();
        slave_rd_strb = s_sr; slave_wr_strb = s_sw; slave_addr = s_sa;
        slave_wr_data = s_sd; slave_wr_be = s_sbe;
        for (int i = 0; i < NB; i++) begin
            bp_req[i] = rem[i] > 0; bp_r[i] = c_r[i]; bp_w[i] = c_w[i];
            bp_addr[i*32 +: 32] = c_addr[i]; bp_d[i*72 +: 72] = c_d[i]; bp_be[i*4 +: 4] = c_be[i];
        end
        @(negedge clk);
        model_check();
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) begin exp_tag[k] = -1; rd_hist[k] = 0; end
        for (int i = 0; i < NB; i++) begin
            rem[i] = 0; c_r[i] = 0; c_w[i] = 0; c_addr[i] = 0; c_d[i] = 0; c_be[i] = 0; waited[i] = 0;
        end
        owner = -1; hold = 0; served = 0; bubble = 0; rr = 0; stall = 0; m_orph = 0; rnd = 0;
        s_rst = 1; s_sr = 0; s_sw = 0; s_sa = 0; s_sd = 0; s_sbe = 0;
        rst = 1; slave_rd_strb = 0; slave_wr_strb = 0; slave_addr = 0; slave_wr_data = 0; slave_wr_be = 0;
        bp_req = 0; bp_r = 0; bp_w = 0; bp_addr = 0; bp_d = 0; bp_be = 0;
        master_rd_data = 0; master_rd_dvld = 0;
        repeat (3) cycle1();
        s_rst = 0;
        repeat (2) cycle1();
        // fabric-only reads
        s_sr = 1; s_sa = 32'h10; cycle1();
        s_sa = 32'h11; cycle1();
        s_sr = 0;
        repeat (14) cycle1();
        // backdoor read arriving alongside a fabric write
        c_r[0] = 1; c_w[0] = 0; c_addr[0] = 32'h55; rem[0] = 1;
        s_sw = 1; s_sa = 32'h3; s_sd = rnd72(); s_sbe = 4'hf;
        cycle1();
        s_sw = 0;
        repeat (16) cycle1();
        // all backdoor ports requesting together
        for (int i = 0; i < NB; i++) begin
            c_r[i] = 1; c_w[i] = 0; c_addr[i] = 32'h100 + 32'(i); rem[i] = 9;
        end
        repeat (60) cycle1();
        // burst limit, then early request drop
        c_r[1] = 0; c_w[1] = 1; c_addr[1] = 32'h200; c_d[1] = rnd72(); c_be[1] = 4'h5; rem[1] = 6;
        repeat (20) cycle1();
        rem[1] = 2;
        repeat (12) cycle1();
        // simultaneous read and write from one port
        c_r[1] = 1; c_w[1] = 1; c_addr[1] = 32'h7; c_d[1] = rnd72(); rem[1] = 1;
        repeat (16) cycle1();
        rnd = 1;
        repeat (1500) cycle1();
        rnd = 0; s_sr = 0; s_sw = 0;
        repeat (80) cycle1();
        // reset while a backdoor read is in flight
        c_r[2] = 1; c_w[2] = 0; c_addr[2] = 32'h77; rem[2] = 1;
        repeat (4) cycle1();
        s_rst = 1;
        repeat (2) cycle1();
        s_rst = 0;
        repeat (12) cycle1();
        chk("orphan_after_reset", rd_orphan, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
